// File: rtl/payment_ledger_if.sv
// Payment-instrument bus between the channel sources and the ledger.
// Channel i transfers on a rising clk edge where pay_valid[i] && pay_ready[i]; ready is a grant, never a precondition for valid.
interface payment_ledger_if #(
  parameter int N_CH   = 3,
  parameter int AMT_W  = 32,
  parameter int NUM_W  = 32,
  parameter int MICR_W = 16
);
  logic [N_CH-1:0]        pay_valid;
  logic [N_CH-1:0]        pay_ready;
  logic [N_CH*NUM_W-1:0]  pay_number;
  logic [N_CH*AMT_W-1:0]  pay_amount;
  logic [N_CH*MICR_W-1:0] pay_micr;

  modport master (output pay_valid, pay_number, pay_amount, pay_micr, input pay_ready);
  modport slave  (input pay_valid, pay_number, pay_amount, pay_micr, output pay_ready);
endinterface

// File: rtl/payment_ledger.sv
// Multi-channel bill-payment ledger: round-robin intake, per-instrument validation,
// running total and end-of-cycle settlement against the amount due.
module payment_ledger #(
  parameter int              N_CH      = 3,
  parameter int              AMT_W     = 32,
  parameter int              NUM_W     = 32,
  parameter int              MICR_W    = 16,
  parameter logic [N_CH-1:0] MICR_REQ  = 3'b110,
  parameter int              DUP_DEPTH = 8,
  localparam int             CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bill_valid,
  input  logic [AMT_W-1:0]  current_month_bill,
  input  logic [AMT_W-1:0]  previous_month_balance,
  payment_ledger_if.slave   pay,
  input  logic              cycle_close,
  output logic [AMT_W-1:0]  paid_total,
  output logic              rej_valid,
  output logic [CH_W-1:0]   rej_channel,
  output logic [1:0]        rej_code,
  output logic              balance_valid,
  output logic [AMT_W-1:0]  next_month_balance,
  output logic [AMT_W-1:0]  excess_payment,
  output logic              busy,
  output logic [1:0]        stateDbg
);

  localparam int             PTR_W   = (DUP_DEPTH > 1) ? $clog2(DUP_DEPTH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } ledgerState_t;

  ledgerState_t state, stateNext;

  logic [AMT_W-1:0]  due;
  logic [CH_W-1:0]   rrPtr;
  logic              histValid [DUP_DEPTH];
  logic [CH_W-1:0]   histCh    [DUP_DEPTH];
  logic [NUM_W-1:0]  histNum   [DUP_DEPTH];
  logic [PTR_W-1:0]  histWrPtr;

  logic              found;
  logic [N_CH-1:0]   grant;
  logic [CH_W-1:0]   grantIdx;
  logic [AMT_W-1:0]  selAmt;
  logic [NUM_W-1:0]  selNum;
  logic [MICR_W-1:0] selMicr;
  logic              selMicrReq;

  logic [AMT_W:0]    paidSum;
  logic [AMT_W:0]    dueSum;
  logic              dupHit;
  logic              reject;
  logic [1:0]        rejCodeNext;

  // Pass 0 searches from the pointer upward, pass 1 wraps to channel 0.
  always_comb begin : grantSel
    found      = 1'b0;
    grant      = '0;
    grantIdx   = '0;
    selAmt     = '0;
    selNum     = '0;
    selMicr    = '0;
    selMicrReq = 1'b0;
    if (state == OPEN) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = 0; i < N_CH; i++) begin
          if (!found && pay.pay_valid[i] && (pass == 1 || i >= int'(rrPtr))) begin
            found      = 1'b1;
            grant[i]   = 1'b1;
            grantIdx   = CH_W'(i);
            selAmt     = pay.pay_amount[i*AMT_W +: AMT_W];
            selNum     = pay.pay_number[i*NUM_W +: NUM_W];
            selMicr    = pay.pay_micr[i*MICR_W +: MICR_W];
            selMicrReq = MICR_REQ[i];
          end
        end
      end
    end
  end

  assign pay.pay_ready = grant;

  always_comb begin : checks
    paidSum = {1'b0, paid_total} + {1'b0, selAmt};
    dueSum  = {1'b0, previous_month_balance} + {1'b0, current_month_bill};
    dupHit  = 1'b0;
    for (int j = 0; j < DUP_DEPTH; j++) begin
      if (histValid[j] && histCh[j] == grantIdx && histNum[j] == selNum) dupHit = 1'b1;
    end
    reject      = 1'b1;
    rejCodeNext = 2'd0;
    if (selAmt == '0)                       rejCodeNext = 2'd0;
    else if (selMicrReq && selMicr == '0)   rejCodeNext = 2'd1;
    else if (dupHit)                        rejCodeNext = 2'd2;
    else if (paidSum[AMT_W])                rejCodeNext = 2'd3;
    else                                    reject      = 1'b0;
  end

  always_comb begin : nextState
    stateNext = state;
    case (state)
      IDLE:    if (bill_valid)  stateNext = OPEN;
      OPEN:    if (cycle_close) stateNext = SETTLE;
      SETTLE:  stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      due                <= '0;
      paid_total         <= '0;
      rrPtr              <= '0;
      rej_valid          <= 1'b0;
      rej_channel        <= '0;
      rej_code           <= '0;
      balance_valid      <= 1'b0;
      next_month_balance <= '0;
      excess_payment     <= '0;
      histWrPtr          <= '0;
      for (int j = 0; j < DUP_DEPTH; j++) begin
        histValid[j] <= 1'b0;
        histCh[j]    <= '0;
        histNum[j]   <= '0;
      end
    end else begin
      rej_valid     <= 1'b0;
      balance_valid <= (state == SETTLE);

      if (state == IDLE && bill_valid) begin
        due        <= dueSum[AMT_W] ? '1 : dueSum[AMT_W-1:0];
        paid_total <= '0;
      end

      if (found) begin
        rrPtr <= (grantIdx == LAST_CH) ? '0 : grantIdx + CH_W'(1);
        if (reject) begin
          rej_valid   <= 1'b1;
          rej_channel <= grantIdx;
          rej_code    <= rejCodeNext;
        end else begin
          paid_total           <= paidSum[AMT_W-1:0];
          histValid[histWrPtr] <= 1'b1;
          histCh[histWrPtr]    <= grantIdx;
          histNum[histWrPtr]   <= selNum;
          histWrPtr            <= histWrPtr + PTR_W'(1);
        end
      end

      if (state == SETTLE) begin
        if (paid_total >= due) begin
          next_month_balance <= '0;
          excess_payment     <= paid_total - due;
        end else begin
          next_month_balance <= due - paid_total;
          excess_payment     <= '0;
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign stateDbg = state;

endmodule

// File: tb/tb_payment_ledger.sv
// Self-checking bench for payment_ledger: vector table for validation rules,
// scripted sequences for round-robin, settlement latency, overflow and reset.
module tb_payment_ledger;
  localparam int N_CH = 3, AMT_W = 32, NUM_W = 32, MICR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              bill_valid;
  logic [AMT_W-1:0]  current_month_bill, previous_month_balance;
  logic              cycle_close;
  logic [AMT_W-1:0]  paid_total, next_month_balance, excess_payment;
  logic              rej_valid, balance_valid, busy;
  logic [1:0]        rej_channel, rej_code, stateDbg;

  always #5 clk = ~clk;

  payment_ledger_if #(.N_CH(N_CH), .AMT_W(AMT_W), .NUM_W(NUM_W), .MICR_W(MICR_W)) pif ();

  payment_ledger #(.N_CH(N_CH), .AMT_W(AMT_W), .NUM_W(NUM_W), .MICR_W(MICR_W),
                   .MICR_REQ(3'b110), .DUP_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bill_valid(bill_valid),
    .current_month_bill(current_month_bill), .previous_month_balance(previous_month_balance),
    .pay(pif), .cycle_close(cycle_close), .paid_total(paid_total),
    .rej_valid(rej_valid), .rej_channel(rej_channel), .rej_code(rej_code),
    .balance_valid(balance_valid), .next_month_balance(next_month_balance),
    .excess_payment(excess_payment), .busy(busy), .stateDbg(stateDbg)
  );

  typedef struct {
    int          ch;
    logic [31:0] amt;
    logic [31:0] num;
    logic [15:0] micr;
    int          code;   // 0..3 reject code, 4 accepted
  } vec_t;

  vec_t        tbl [11];
  logic [36:0] exp_q [$];   // {rej, channel[2], code[2], paid_total[32]}
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] modelPaid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_pay();
    pif.pay_valid  = '0;
    pif.pay_amount = '0;
    pif.pay_number = '0;
    pif.pay_micr   = '0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] amt, input logic [31:0] num, input logic [15:0] micr);
    pif.pay_valid[ch]            = 1'b1;
    pif.pay_amount[ch*32 +: 32]  = amt;
    pif.pay_number[ch*32 +: 32]  = num;
    pif.pay_micr[ch*16 +: 16]    = micr;
  endtask

  task automatic expect_result(input int ch, input logic [31:0] amt, input int code);
    if (code == 4) begin
      modelPaid = modelPaid + amt;
      exp_q.push_back({1'b0, 2'd0, 2'd0, modelPaid});
    end else begin
      exp_q.push_back({1'b1, 2'(ch), 2'(code), modelPaid});
    end
  endtask

  task automatic pop_check(input string tag);
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " rej_valid"}, 64'(rej_valid), 64'(e[36]));
      if (e[36]) begin
        check({tag, " rej_channel"}, 64'(rej_channel), 64'(e[35:34]));
        check({tag, " rej_code"}, 64'(rej_code), 64'(e[33:32]));
      end
      check({tag, " paid_total"}, 64'(paid_total), 64'(e[31:0]));
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic drive_pay(input string tag, input int ch, input logic [31:0] amt, input logic [31:0] num,
                           input logic [15:0] micr, input int code, input bit close);
    clear_pay();
    set_ch(ch, amt, num, micr);
    cycle_close = close;
    #1;
    check({tag, " grant"}, 64'(pif.pay_ready), 64'(3'b001 << ch));
    expect_result(ch, amt, code);
    @(posedge clk); #1;
    clear_pay();
    cycle_close = 1'b0;
    pop_check(tag);
  endtask

  task automatic open_bill(input string tag, input logic [31:0] bill, input logic [31:0] prev);
    bill_valid = 1'b1;
    current_month_bill = bill;
    previous_month_balance = prev;
    @(posedge clk); #1;
    bill_valid = 1'b0;
    modelPaid = '0;
    check({tag, " open state"}, 64'(stateDbg), 64'd1);
    check({tag, " open paid_total"}, 64'(paid_total), 64'd0);
  endtask

  // Called just after the edge that sampled cycle_close.
  task automatic settle_check(input string tag, input logic [31:0] expNext, input logic [31:0] expExcess);
    check({tag, " settle balance_valid"}, 64'(balance_valid), 64'd0);
    check({tag, " settle state"}, 64'(stateDbg), 64'd2);
    check({tag, " settle pay_ready"}, 64'(pif.pay_ready), 64'd0);
    clear_pay();
    @(posedge clk); #1;
    check({tag, " done balance_valid"}, 64'(balance_valid), 64'd1);
    check({tag, " next_month_balance"}, 64'(next_month_balance), 64'(expNext));
    check({tag, " excess_payment"}, 64'(excess_payment), 64'(expExcess));
    check({tag, " done busy"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    check({tag, " pulse end"}, 64'(balance_valid), 64'd0);
    check({tag, " idle busy"}, 64'(busy), 64'd0);
    check({tag, " result hold"}, 64'(next_month_balance), 64'(expNext));
  endtask

  task automatic close_cycle(input string tag, input logic [31:0] expNext, input logic [31:0] expExcess);
    cycle_close = 1'b1;
    @(posedge clk); #1;
    cycle_close = 1'b0;
    settle_check(tag, expNext, expExcess);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " paid_total"}, 64'(paid_total), 64'd0);
    check({tag, " rej_valid"}, 64'(rej_valid), 64'd0);
    check({tag, " rej_channel"}, 64'(rej_channel), 64'd0);
    check({tag, " rej_code"}, 64'(rej_code), 64'd0);
    check({tag, " balance_valid"}, 64'(balance_valid), 64'd0);
    check({tag, " next_month_balance"}, 64'(next_month_balance), 64'd0);
    check({tag, " excess_payment"}, 64'(excess_payment), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " state"}, 64'(stateDbg), 64'd0);
    check({tag, " pay_ready"}, 64'(pif.pay_ready), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{1, 32'd200, 32'd7000, 16'd0,  1};
    tbl[1]  = '{0, 32'd0,   32'd7001, 16'd0,  0};
    tbl[2]  = '{2, 32'd150, 32'd5432, 16'd55, 4};
    tbl[3]  = '{2, 32'd150, 32'd5432, 16'd55, 2};
    tbl[4]  = '{0, 32'd150, 32'd5432, 16'd0,  4};
    tbl[5]  = '{0, 32'd10,  32'd1234, 16'd0,  2};
    tbl[6]  = '{1, 32'd20,  32'd5678, 16'd1,  2};
    tbl[7]  = '{1, 32'd0,   32'd9999, 16'd0,  0};
    tbl[8]  = '{2, 32'd0,   32'd5432, 16'd0,  0};
    tbl[9]  = '{2, 32'd25,  32'd5432, 16'd0,  1};
    tbl[10] = '{2, 32'd30,  32'd8000, 16'd3,  4};

    reset = 1'b0;
    bill_valid = 1'b0;
    cycle_close = 1'b0;
    current_month_bill = '0;
    previous_month_balance = '0;
    modelPaid = '0;
    clear_pay();
    set_ch(0, 32'd5, 32'd1, 16'd0);
    set_ch(1, 32'd5, 32'd2, 16'd1);
    set_ch(2, 32'd5, 32'd3, 16'd1);
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    clear_pay();
    reset = 1'b1;
    @(posedge clk); #1;

    // Cash payment, partial settlement, close-to-result latency.
    open_bill("A", 32'd150, 32'd0);
    drive_pay("A pay", 0, 32'd100, 32'd1234, 16'd0, 4, 1'b0);
    close_cycle("A", 32'd50, 32'd0);

    // Cheque payment; bill_valid while OPEN must be ignored.
    open_bill("B", 32'd300, 32'd50);
    #1;
    check("B no valid grant", 64'(pif.pay_ready), 64'd0);
    drive_pay("B pay", 1, 32'd200, 32'd5678, 16'd9876, 4, 1'b0);
    bill_valid = 1'b1;
    current_month_bill = 32'd7;
    previous_month_balance = 32'd7;
    @(posedge clk); #1;
    bill_valid = 1'b0;
    check("B ignore bill paid", 64'(paid_total), 64'd200);
    check("B ignore bill state", 64'(stateDbg), 64'd1);
    close_cycle("B", 32'd150, 32'd0);

    // Validation rules and their priority, including history from earlier cycles.
    open_bill("C", 32'd1000, 32'd0);
    for (int r = 0; r < 11; r++) begin
      drive_pay($sformatf("C row%0d", r), tbl[r].ch, tbl[r].amt, tbl[r].num, tbl[r].micr, tbl[r].code, 1'b0);
    end
    close_cycle("C", 32'd670, 32'd0);

    // Two channels at once from pointer 0; close together with the second handshake.
    open_bill("D", 32'd200, 32'd0);
    clear_pay();
    set_ch(0, 32'd100, 32'd100, 16'd0);
    set_ch(2, 32'd100, 32'd102, 16'd5);
    #1;
    check("D grant first", 64'(pif.pay_ready), 64'b001);
    expect_result(0, 32'd100, 4);
    @(posedge clk); #1;
    pop_check("D ch0");
    check("D grant rotate", 64'(pif.pay_ready), 64'b100);
    cycle_close = 1'b1;
    expect_result(2, 32'd100, 4);
    @(posedge clk); #1;
    cycle_close = 1'b0;
    pop_check("D ch2");
    settle_check("D", 32'd0, 32'd0);

    // All three requesting; overpayment credit.
    open_bill("E", 32'd200, 32'd0);
    clear_pay();
    set_ch(0, 32'd100, 32'd200, 16'd0);
    set_ch(1, 32'd50,  32'd201, 16'd7);
    set_ch(2, 32'd100, 32'd202, 16'd8);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("E grant%0d", c), 64'(pif.pay_ready), 64'(3'b001 << c));
      expect_result(c, (c == 1) ? 32'd50 : 32'd100, 4);
      @(posedge clk); #1;
      pif.pay_valid[c] = 1'b0;
      pop_check($sformatf("E ch%0d", c));
    end
    close_cycle("E", 32'd0, 32'd50);

    // Saturated due and paid_total overflow boundary.
    open_bill("F", 32'hFFFF_FFFF, 32'h10);
    drive_pay("F big", 0, 32'hFFFF_FFF0, 32'd1, 16'd0, 4, 1'b0);
    drive_pay("F ovf", 0, 32'h20, 32'd2, 16'd0, 3, 1'b0);
    drive_pay("F fill", 0, 32'h0F, 32'd3, 16'd0, 4, 1'b0);
    drive_pay("F ovf1", 1, 32'h1, 32'd4, 16'd5, 3, 1'b0);
    close_cycle("F", 32'd0, 32'd0);

    // History wraps: oldest entries are forgotten, recent ones still reject.
    open_bill("G", 32'd100, 32'd0);
    drive_pay("G wrapped", 0, 32'd10, 32'd1234, 16'd0, 4, 1'b0);
    drive_pay("G recent", 2, 32'd10, 32'd102, 16'd9, 2, 1'b0);
    drive_pay("G wrapped2", 2, 32'd10, 32'd5432, 16'd9, 4, 1'b0);

    // Reset in OPEN aborts without a settlement pulse.
    reset = 1'b0;
    #1;
    check_zero_outputs("midreset");
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("midreset hold%0d", c), 64'(balance_valid), 64'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("postreset bv%0d", c), 64'(balance_valid), 64'd0);
      check($sformatf("postreset busy%0d", c), 64'(busy), 64'd0);
    end

    // cycle_close alone in IDLE is ignored; with bill_valid only the bill acts.
    cycle_close = 1'b1;
    @(posedge clk); #1;
    check("H close in idle", 64'(busy), 64'd0);
    bill_valid = 1'b1;
    current_month_bill = 32'd10;
    previous_month_balance = 32'd0;
    @(posedge clk); #1;
    bill_valid = 1'b0;
    cycle_close = 1'b0;
    modelPaid = '0;
    check("H bill wins", 64'(stateDbg), 64'd1);
    @(posedge clk); #1;
    check("H still open", 64'(stateDbg), 64'd1);
    drive_pay("H history cleared", 2, 32'd10, 32'd102, 16'd9, 4, 1'b0);
    close_cycle("H", 32'd0, 32'd0);

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/payment_ledger.md
Name: payment_ledger

Overview:
- Multi-channel bill-payment ledger; successor to the fixed three-input cash/cheque/DD billing block.
- Accepts up to N_CH payment instruments per billing cycle over valid/ready handshakes, one per clock via round-robin.
- Validates each instrument for zero amount, MICR presence and duplicate number, and keeps a running total.
- On cycle close, settles against previous balance plus current bill and emits next-month balance and excess payment.

Parameters:
- N_CH, 3, number of payment channels (ch0 cash, ch1 cheque, ch2 DD by convention).
- AMT_W, 32, width of amounts, bill, balances.
- NUM_W, 32, width of instrument number.
- MICR_W, 16, width of MICR field.
- MICR_REQ, 3'b110, N_CH-bit mask; a set bit means the channel requires a nonzero MICR.
- DUP_DEPTH, 8, entries in the duplicate-number history (power of 2).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- bill_valid  in  1  opens a billing cycle; samples bill and previous balance.
- current_month_bill  in  AMT_W  bill for this cycle.
- previous_month_balance  in  AMT_W  carried-over balance.
- pay_valid  in  N_CH  per-channel payment request.
- pay_ready  out  N_CH  one-hot grant; at most one bit high.
- pay_number  in  N_CH*NUM_W  packed instrument numbers; ch i at [i*NUM_W +: NUM_W].
- pay_amount  in  N_CH*AMT_W  packed amounts.
- pay_micr  in  N_CH*MICR_W  packed MICR fields.
- cycle_close  in  1  requests settlement.
- paid_total  out  AMT_W  running sum of accepted payments.
- rej_valid  out  1  one-cycle pulse for a rejected handshake.
- rej_channel  out  $clog2(N_CH)  channel of the rejected payment.
- rej_code  out  2  0 zero amount, 1 missing MICR, 2 duplicate, 3 overflow.
- balance_valid  out  1  one-cycle pulse with settlement result.
- next_month_balance  out  AMT_W  amount still due.
- excess_payment  out  AMT_W  overpayment credit.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; dup history entries invalid; round-robin pointer 0.
- States:
  - IDLE: on bill_valid, latch due = previous_month_balance + current_month_bill (saturate at 2^AMT_W-1), clear paid_total, go to OPEN.
  - OPEN: pay_ready is a combinational one-hot grant to the first pay_valid channel at or after the RR pointer. It is never granted when pay_valid is low.
  - Handshake: pay_valid[i] & pay_ready[i].
    - The RR pointer moves to i+1 (mod N_CH) after every handshake, accepted or rejected.
  - Checks on a handshake, in priority order:
    - amount==0 → code 0.
    - MICR_REQ[i] and micr==0 → code 1.
    - {i,number} matches a valid history entry → code 2.
    - paid_total+amount exceeds 2^AMT_W-1 → code 3.
  - Rejection: rej_valid/rej_channel/rej_code registered, visible the next cycle. paid_total and history are unchanged.
  - Acceptance: paid_total += amount (visible the next cycle); {i,number} written at the history write pointer. The pointer wraps, overwriting the oldest entry.
  - History persists across billing cycles and is cleared only by reset.
  - cycle_close in OPEN → SETTLE. A handshake in the same cycle is still processed and counted. pay_ready is 0 from SETTLE onward.
  - SETTLE, one cycle:
    - If paid_total ≥ due: next_month_balance=0, excess_payment=paid_total-due.
    - Otherwise: next_month_balance=due-paid_total, excess_payment=0.
    - Go to DONE.
  - DONE: balance_valid=1 for exactly one cycle; results hold until the next settlement or reset; go to IDLE.
- Latency: cycle_close sampled at edge k → balance_valid high during cycle k+2.
- Ignored inputs:
  - bill_valid outside IDLE.
  - cycle_close outside OPEN.
  - bill_valid and cycle_close together in IDLE: only bill_valid acts.
- Reset mid-cycle: aborts immediately; no balance_valid; history lost.

Test Plan:
- Bill 150, prev 0, ch0 cash amount 100 #1234, close → paid_total 100, next_month_balance 50, excess 0, balance_valid 2 cycles after close.
- Bill 300, prev 50, ch1 cheque 200 #5678 MICR 9876, close → next 150, excess 0.
- ch1 cheque amount 200, MICR 0 → rej_valid, rej_channel 1, rej_code 1; paid_total unchanged. ch0 amount 0 → rej_code 0.
- ch2 DD #5432 amount 150 accepted; same number resubmitted (also in a later cycle) → rej_code 2. Same number on ch0 → accepted.
- Bill 200, ch0 and ch2 valid together (100 each, RR pointer 0) → ch0 granted, then ch2 on the next cycle; paid_total 200; close together with ch2's handshake → next 0, excess 0. Add 50 more before close → excess 50.
- Paid_total 0xFFFFFFF0 plus amount 0x20 → rej_code 3. Reset asserted in OPEN → all outputs 0, IDLE, no balance_valid.
